// File: rtl/ppi_link_pkg.sv
// ppi_link_pkg
// Shared types for the 8255-style strobed PPI link: the TX and RX handshake
// state encodings and the width of the pulse-length counters.
// No ports; imported by ppi_link_fifo and ppi_strobe_link.

package ppi_link_pkg;

  // Pulse lengths are 1..15 cycles, so a 4-bit down-counter is enough.
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    T_IDLE,
    T_SETUP,
    T_STROBE,
    T_WAIT_HI,
    T_WAIT_LO
  } tx_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ACK,
    R_RELEASE
  } rx_state_e;

endpackage

// File: rtl/ppi_link_fifo.sv
// ppi_link_fifo
// Synchronous 8-bit first-in first-out buffer with a power-of-two depth.
// Ports:
//   clk, reset      clock and synchronous active-high reset (empties the FIFO)
//   push, push_data write one byte when not full (ignored while full)
//   pop             drop the head byte when not empty (ignored while empty)
//   head_data       byte at the head; reads 8'h00 while empty
//   full, empty     occupancy flags

module ppi_link_fifo
  import ppi_link_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // A defined value while empty keeps rx_data clean when nothing is queued.
  assign head_data = empty ? 8'h00 : mem[rd_ptr];

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ppi_strobe_link.sv
// ppi_strobe_link
// Byte link to an 8255 PPI running port A in mode-1 input and port B in
// mode-1 output. A TX engine strobes queued bytes into port A (stb_n/ibf);
// an RX engine acknowledges bytes from port B (obf_n/ack_n) into a queue.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   tx_data/valid/ready    byte stream toward the CPU (into the TX FIFO)
//   pa_out, stb_n, ibf     PPI port A pins, PC4 strobe, PC5 input-buffer-full
//   pb_in, obf_n, ack_n    PPI port B pins, PC1 output-buffer-full, PC2 ack
//   rx_data/valid/ready    byte stream from the CPU (out of the RX FIFO)
//   busy                   either handshake engine is mid-transfer

module ppi_strobe_link
  import ppi_link_pkg::*;
#(
  parameter int STB_CYCLES = 4,
  parameter int ACK_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] pa_out,
  output logic       stb_n,
  input  logic       ibf,
  input  logic [7:0] pb_in,
  input  logic       obf_n,
  output logic       ack_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy
);

  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STB_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_CYCLES - 1);

  tx_state_e        tx_state_q, tx_state_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] stb_cnt_q, stb_cnt_d;
  logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;

  logic       tx_full, tx_empty, tx_pop;
  logic [7:0] tx_head;
  logic       rx_full, rx_empty, rx_push;

  // Gating with reset keeps producers stalled while the link is held in reset.
  assign tx_ready = ~tx_full & ~reset;
  assign rx_valid = ~rx_empty;
  assign busy     = ~reset & ((tx_state_q != T_IDLE) | (rx_state_q != R_IDLE));

  ppi_link_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_valid & tx_ready),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head_data (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  ppi_link_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (pb_in),
    .pop       (rx_valid & rx_ready),
    .head_data (rx_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // TX next-state: a byte leaves the FIFO only once the PPI input latch is
  // free, gets one setup cycle on port A, then a fixed-width strobe, then we
  // follow ibf through the CPU's read of the latch.
  always_comb begin
    tx_state_d = tx_state_q;
    stb_cnt_d  = stb_cnt_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!tx_empty && !ibf) begin
          tx_state_d = T_SETUP;
          tx_pop     = 1'b1;
        end
      end
      T_SETUP: begin
        tx_state_d = T_STROBE;
        stb_cnt_d  = STB_LAST;
      end
      T_STROBE: begin
        if (stb_cnt_q == '0) begin
          tx_state_d = T_WAIT_HI;
        end else begin
          stb_cnt_d = stb_cnt_q - 1'b1;
        end
      end
      T_WAIT_HI: begin
        if (ibf) begin
          tx_state_d = T_WAIT_LO;
        end
      end
      T_WAIT_LO: begin
        if (!ibf) begin
          tx_state_d = T_IDLE;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // stb_n is registered from the next state so the pin never glitches on a
  // multi-bit state change; pa_out holds the last byte between transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= T_IDLE;
      stb_cnt_q  <= '0;
      stb_n      <= 1'b1;
      pa_out     <= 8'hFF;
    end else begin
      tx_state_q <= tx_state_d;
      stb_cnt_q  <= stb_cnt_d;
      stb_n      <= (tx_state_d != T_STROBE);
      if (tx_pop) begin
        pa_out <= tx_head;
      end
    end
  end

  // RX next-state: acknowledge only when there is room, so a pushed byte can
  // never overflow. The byte on port B is taken on the final ack edge, and we
  // insist on obf_n returning high so one CPU write yields exactly one byte.
  always_comb begin
    rx_state_d = rx_state_q;
    ack_cnt_d  = ack_cnt_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (!obf_n && !rx_full) begin
          rx_state_d = R_ACK;
          ack_cnt_d  = ACK_LAST;
        end
      end
      R_ACK: begin
        if (ack_cnt_q == '0) begin
          rx_state_d = R_RELEASE;
          rx_push    = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q - 1'b1;
        end
      end
      R_RELEASE: begin
        if (obf_n) begin
          rx_state_d = R_IDLE;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // ack_n is registered from the next state for the same glitch-free reason.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= R_IDLE;
      ack_cnt_q  <= '0;
      ack_n      <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      ack_cnt_q  <= ack_cnt_d;
      ack_n      <= (rx_state_d != R_ACK);
    end
  end

endmodule

// File: tb/tb_ppi_strobe_link.sv
// tb_ppi_strobe_link
// Directed bench for ppi_strobe_link: reset values, single TX strobe timing,
// TX FIFO full with the PPI latch busy, single RX ack timing, RX FIFO full
// back-pressure, reset mid-handshake and a concurrent 64-byte stream.

module tb_ppi_strobe_link;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] pa_out;
  logic       stb_n;
  logic       ibf = 1'b0;
  logic [7:0] pb_in = 8'h00;
  logic       obf_n = 1'b1;
  logic       ack_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  ppi_strobe_link #(.STB_CYCLES(4), .ACK_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .pa_out   (pa_out),
    .stb_n    (stb_n),
    .ibf      (ibf),
    .pb_in    (pb_in),
    .obf_n    (obf_n),
    .ack_n    (ack_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are observed on the falling edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; ibf = 1'b0;
    pb_in = 8'h00; obf_n = 1'b1; rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One full port-B write from the CPU side; reports ack width and delay.
  task automatic send_rx(input logic [7:0] b, output int low_cnt, output int wait_cnt);
    @(negedge clk);
    pb_in = b; obf_n = 1'b0; low_cnt = 0; wait_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ack_n === 1'b0) low_cnt++;
      else if (low_cnt > 0) break;
      else wait_cnt++;
    end
    obf_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (stb_n !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_stb_n: got %b, expected 1", stb_n); end
    vectors++; if (ack_n !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ack_n: got %b, expected 1", ack_n); end
    vectors++; if (pa_out !== 8'hFF) begin miscompares++; $display("[TB] FAIL reset_pa_out: got %h, expected ff", pa_out); end
    vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_ready: got %b, expected 0", tx_ready); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rx_valid: got %b, expected 0", rx_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rx_data: got %h, expected 00", rx_data); end
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_tx_ready: got %b, expected 1", tx_ready); end
  endtask

  task automatic test_tx_single();
    int low_cnt, first_low, pa_cycle;
    do_reset();
    low_cnt = 0; first_low = -1; pa_cycle = -1;
    tx_data = 8'hA5; tx_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      if (pa_out === 8'hA5 && pa_cycle < 0) pa_cycle = c;
      if (stb_n === 1'b0) begin
        if (first_low < 0) first_low = c;
        low_cnt++;
      end
      if (c == 5) begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_busy_mid: got %b, expected 1", busy); end
      end
      if (first_low >= 0 && c == first_low + 2) ibf = 1'b1;
      if (first_low >= 0 && c == first_low + 7) ibf = 1'b0;
    end
    vectors++; if (pa_cycle != 1) begin miscompares++; $display("[TB] FAIL tx_pa_cycle: got %0d, expected 1", pa_cycle); end
    vectors++; if (first_low != 2) begin miscompares++; $display("[TB] FAIL tx_stb_start: got %0d, expected 2", first_low); end
    vectors++; if (low_cnt != 4) begin miscompares++; $display("[TB] FAIL tx_stb_width: got %0d, expected 4", low_cnt); end
    vectors++; if (pa_out !== 8'hA5) begin miscompares++; $display("[TB] FAIL tx_pa_hold: got %h, expected a5", pa_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_busy_end: got %b, expected 0", busy); end
  endtask

  task automatic test_tx_blocked();
    int low_cnt, cpu_t;
    logic [7:0] cap[$];
    logic [7:0] want;
    do_reset();
    ibf = 1'b1; low_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 3) begin
        vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL blk_ready_before_4th: got %b, expected 1", tx_ready); end
      end
      if (i == 4) begin
        vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL blk_ready_after_4th: got %b, expected 0", tx_ready); end
      end
      tx_data = 8'(i + 1); tx_valid = 1'b1;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (stb_n === 1'b0) low_cnt++;
    end
    vectors++; if (low_cnt != 0) begin miscompares++; $display("[TB] FAIL blk_no_strobe: got %0d low cycles, expected 0", low_cnt); end
    vectors++; if (pa_out !== 8'hFF) begin miscompares++; $display("[TB] FAIL blk_pa_out: got %h, expected ff", pa_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL blk_busy: got %b, expected 0", busy); end
    // Release the latch and let a CPU model read everything that was queued.
    ibf = 1'b0; cpu_t = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cpu_t == 0) begin
        if (stb_n === 1'b0) begin cap.push_back(pa_out); cpu_t = 1; end
      end else begin
        cpu_t++;
        if (cpu_t == 3) ibf = 1'b1;
        if (cpu_t == 8) begin ibf = 1'b0; cpu_t = 0; end
      end
    end
    vectors++; if (cap.size() != 4) begin miscompares++; $display("[TB] FAIL blk_sent_count: got %0d, expected 4", cap.size()); end
    for (int i = 0; i < 4 && i < cap.size(); i++) begin
      want = 8'(i + 1);
      vectors++; if (cap[i] !== want) begin miscompares++; $display("[TB] FAIL blk_order[%0d]: got %h, expected %h", i, cap[i], want); end
    end
  endtask

  task automatic test_rx_single();
    int low_cnt, first_valid, l2, w2;
    do_reset();
    low_cnt = 0; first_valid = -1;
    pb_in = 8'h3C; obf_n = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (ack_n === 1'b0) low_cnt++;
      if (rx_valid === 1'b1 && first_valid < 0) first_valid = c;
    end
    vectors++; if (low_cnt != 4) begin miscompares++; $display("[TB] FAIL rx_ack_width_held: got %0d, expected 4", low_cnt); end
    vectors++; if (first_valid != 4) begin miscompares++; $display("[TB] FAIL rx_valid_cycle: got %0d, expected 4", first_valid); end
    vectors++; if (rx_data !== 8'h3C) begin miscompares++; $display("[TB] FAIL rx_data_first: got %h, expected 3c", rx_data); end
    obf_n = 1'b1;
    repeat (2) @(negedge clk);
    send_rx(8'h5A, l2, w2);
    vectors++; if (l2 != 4) begin miscompares++; $display("[TB] FAIL rx_ack_width_2nd: got %0d, expected 4", l2); end
    vectors++; if (w2 != 0) begin miscompares++; $display("[TB] FAIL rx_ack_delay_2nd: got %0d, expected 0", w2); end
    rx_ready = 1'b1;
    vectors++; if (rx_data !== 8'h3C) begin miscompares++; $display("[TB] FAIL rx_pop0: got %h, expected 3c", rx_data); end
    @(negedge clk);
    vectors++; if (rx_data !== 8'h5A) begin miscompares++; $display("[TB] FAIL rx_pop1: got %h, expected 5a", rx_data); end
    @(negedge clk);
    rx_ready = 1'b0;
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_drained: got %b, expected 0", rx_valid); end
  endtask

  task automatic test_rx_full();
    int l, w, held_low, delay;
    logic [7:0] want;
    do_reset();
    for (int i = 0; i < 4; i++) send_rx(8'(8'h10 + i), l, w);
    pb_in = 8'h14; obf_n = 1'b0; held_low = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack_n === 1'b0) held_low++;
    end
    vectors++; if (held_low != 0) begin miscompares++; $display("[TB] FAIL full_ack_held: got %0d low cycles, expected 0", held_low); end
    rx_ready = 1'b1;
    vectors++; if (rx_data !== 8'h10) begin miscompares++; $display("[TB] FAIL full_pop_data: got %h, expected 10", rx_data); end
    @(negedge clk);
    rx_ready = 1'b0;
    delay = -1;
    for (int c = 1; c <= 6; c++) begin
      if (ack_n === 1'b0 && delay < 0) delay = c;
      @(negedge clk);
    end
    vectors++; if (delay < 1 || delay > 2) begin miscompares++; $display("[TB] FAIL full_ack_delay: got %0d cycles, expected 1..2", delay); end
    for (int c = 0; c < 10 && ack_n === 1'b0; c++) @(negedge clk);
    obf_n = 1'b1;
    @(negedge clk);
    rx_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      want = 8'(8'h10 + i);
      vectors++; if (rx_valid !== 1'b1 || rx_data !== want) begin miscompares++; $display("[TB] FAIL full_order[%0d]: got %h valid %b, expected %h", i, rx_data, rx_valid, want); end
      @(negedge clk);
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_midway();
    int found, low_after;
    do_reset();
    tx_data = 8'h77; tx_valid = 1'b1; pb_in = 8'h99; obf_n = 1'b0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      if (stb_n === 1'b0) begin found = 1; break; end
    end
    vectors++; if (found != 1) begin miscompares++; $display("[TB] FAIL mid_reach_strobe: got %0d, expected 1", found); end
    vectors++; if (ack_n !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_in_ack: got %b, expected 0", ack_n); end
    reset = 1'b1; obf_n = 1'b1;
    @(negedge clk);
    vectors++; if (stb_n !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_stb_n: got %b, expected 1", stb_n); end
    vectors++; if (ack_n !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_ack_n: got %b, expected 1", ack_n); end
    vectors++; if (pa_out !== 8'hFF) begin miscompares++; $display("[TB] FAIL mid_pa_out: got %h, expected ff", pa_out); end
    reset = 1'b0;
    low_after = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (stb_n === 1'b0 || ack_n === 1'b0) low_after++;
    end
    vectors++; if (low_after != 0) begin miscompares++; $display("[TB] FAIL mid_no_resume: got %0d, expected 0", low_after); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rx_empty: got %b, expected 0", rx_valid); end
    vectors++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_idle: got ready %b busy %b, expected 1 0", tx_ready, busy); end
  endtask

  task automatic test_concurrent();
    logic [7:0] tx_bytes[64];
    logic [7:0] rx_bytes[64];
    int tx_idx, tx_got, src, rx_got, p_state, cpu_t;
    logic tx_acc;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      tx_bytes[i] = 8'($urandom);
      rx_bytes[i] = 8'($urandom);
    end
    tx_idx = 0; tx_got = 0; src = 0; rx_got = 0; p_state = 0; cpu_t = 0; tx_acc = 1'b0;
    for (int cyc = 0; cyc < 20000 && !(tx_got == 64 && rx_got == 64); cyc++) begin
      @(negedge clk);
      if (tx_acc) tx_idx++;
      tx_valid = (tx_idx < 64) && ($urandom_range(0, 3) != 0);
      if (tx_valid) tx_data = tx_bytes[tx_idx];
      tx_acc = tx_valid && (tx_ready === 1'b1);
      if (cpu_t == 0) begin
        if (stb_n === 1'b0) begin
          vectors++;
          if (tx_got >= 64) begin miscompares++; $display("[TB] FAIL cc_tx_extra: got %h, expected none", pa_out); end
          else if (pa_out !== tx_bytes[tx_got]) begin miscompares++; $display("[TB] FAIL cc_tx[%0d]: got %h, expected %h", tx_got, pa_out, tx_bytes[tx_got]); end
          tx_got++;
          cpu_t = 1;
        end
      end else begin
        cpu_t++;
        if (cpu_t == 3) ibf = 1'b1;
        if (cpu_t == 8) begin ibf = 1'b0; cpu_t = 0; end
      end
      case (p_state)
        0: if (src < 64 && $urandom_range(0, 2) != 0) begin pb_in = rx_bytes[src]; obf_n = 1'b0; p_state = 1; end
        1: if (ack_n === 1'b0) p_state = 2;
        default: if (ack_n === 1'b1) begin obf_n = 1'b1; src++; p_state = 0; end
      endcase
      rx_ready = 1'($urandom_range(0, 1));
      if (rx_valid === 1'b1 && rx_ready) begin
        vectors++;
        if (rx_got >= 64) begin miscompares++; $display("[TB] FAIL cc_rx_extra: got %h, expected none", rx_data); end
        else if (rx_data !== rx_bytes[rx_got]) begin miscompares++; $display("[TB] FAIL cc_rx[%0d]: got %h, expected %h", rx_got, rx_data, rx_bytes[rx_got]); end
        rx_got++;
      end
    end
    tx_valid = 1'b0; rx_ready = 1'b0;
    vectors++; if (tx_got != 64) begin miscompares++; $display("[TB] FAIL cc_tx_count: got %0d, expected 64", tx_got); end
    vectors++; if (rx_got != 64) begin miscompares++; $display("[TB] FAIL cc_rx_count: got %0d, expected 64", rx_got); end
  endtask

  initial begin
    $display("[TB] ppi_strobe_link directed tests");
    test_reset();
    test_tx_single();
    test_tx_blocked();
    test_rx_single();
    test_rx_full();
    test_reset_midway();
    test_concurrent();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ppi_strobe_link.md
PPI_STROBE_LINK -- requirements
Module: ppi_strobe_link

Interface
REQ-001 Parameter STB_CYCLES, 4, width of the stb_n low pulse in clk cycles (range 1..15).
REQ-002 Parameter ACK_CYCLES, 4, width of the ack_n low pulse in clk cycles (range 1..15).
REQ-003 Parameter FIFO_DEPTH, 4, entries per direction (power of two, 2..16).
REQ-004 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 tx_data  in  8  byte to send toward the CPU (PPI port A input).
REQ-008 tx_valid  in  1  tx_data is valid.
REQ-009 tx_ready  out  1  TX FIFO can accept a byte.
REQ-010 pa_out  out  8  byte driven onto the PPI port A input pins.
REQ-011 stb_n  out  1  strobe to PPI PC4, active low.
REQ-012 ibf  in  1  input-buffer-full from PPI PC5, active high.
REQ-013 pb_in  in  8  byte from the PPI port B output pins.
REQ-014 obf_n  in  1  output-buffer-full from PPI PC1, active low.
REQ-015 ack_n  out  1  acknowledge to PPI PC2, active low.
REQ-016 rx_data  out  8  received byte from FIFO head.
REQ-017 rx_valid  out  1  RX FIFO not empty.
REQ-018 rx_ready  in  1  consumer accepts rx_data.
REQ-019 busy  out  1  either handshake engine is not idle.

Function
REQ-020 TX push occurs on a clk edge with tx_valid&tx_ready; tx_ready = TX FIFO not full, with no bypass while full.
REQ-021 TX FSM states: T_IDLE, T_SETUP, T_STROBE, T_WAIT_HI, T_WAIT_LO.
REQ-022 T_IDLE->T_SETUP when TX FIFO not empty and ibf=0; the head byte is popped into pa_out register on that edge.
REQ-023 T_SETUP lasts exactly 1 cycle with stb_n=1 and pa_out stable, then ->T_STROBE.
REQ-024 T_STROBE drives stb_n=0 for exactly STB_CYCLES cycles, then ->T_WAIT_HI.
REQ-025 T_WAIT_HI waits for ibf=1, then ->T_WAIT_LO; T_WAIT_LO waits for ibf=0 (CPU read), then ->T_IDLE.
REQ-026 pa_out SHALL hold the last sent byte until the next T_IDLE->T_SETUP transition.
REQ-027 RX FSM states: R_IDLE, R_ACK, R_RELEASE.
REQ-028 R_IDLE->R_ACK when obf_n=0 and RX FIFO not full; if the FIFO is full, ack_n stays high and the byte waits.
REQ-029 R_ACK drives ack_n=0 for exactly ACK_CYCLES cycles; pb_in is captured on the last R_ACK edge and pushed into the RX FIFO on that edge.
REQ-030 R_RELEASE waits for obf_n=1, then ->R_IDLE; ack_n=1 in R_RELEASE and R_IDLE.
REQ-031 RX pop occurs on rx_valid&rx_ready; simultaneous push and pop in one cycle keeps the count unchanged.
REQ-032 Both FIFOs are first-in first-out; pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-033 TX and RX engines are independent and may run concurrently.
REQ-034 busy = (TX state != T_IDLE) | (RX state != R_IDLE).

Reset
REQ-035 During reset: stb_n=1, ack_n=1, pa_out=8'hFF, both FIFOs empty, tx_ready=0, rx_valid=0, busy=0, rx_data=8'h00, and both FSMs idle.
REQ-036 On the first cycle after reset: tx_ready=1.
REQ-037 Reset asserted mid-handshake SHALL return stb_n and ack_n high on the next edge and discard the in-flight byte.

Structure
REQ-038 Package ppi_link_pkg SHALL hold the TX/RX state enums and the strobe/ack counter width constant.
REQ-039 One sub-module, ppi_link_fifo (8-bit, parameterised depth, synchronous), SHALL be instantiated twice.

Verification
REQ-040 Push 8'hA5 with ibf tied to follow stb_n (rise 2 cycles after stb_n falls, fall 5 cycles later) -> pa_out=8'hA5 one cycle before stb_n low, stb_n low exactly 4 cycles.
REQ-041 Push 8'h01,8'h02,8'h03,8'h04,8'h05 back-to-back with ibf held 1 -> tx_ready low after the 4th push, no strobe occurs, and pa_out keeps 8'hFF.
REQ-042 Drive pb_in=8'h3C, obf_n=0 -> ack_n low 4 cycles, rx_data=8'h3C and rx_valid=1 after ack; hold obf_n low -> no second ack until obf_n rises and falls again.
REQ-043 Fill the RX FIFO (4 bytes, rx_ready=0), then set obf_n=0 -> ack_n stays 1; pulse rx_ready once -> ack begins within 2 cycles.
REQ-044 Assert reset during T_STROBE and during R_ACK -> stb_n=1 and ack_n=1 next cycle, and the FIFOs are empty.
REQ-045 Run TX and RX concurrently for 64 random bytes each -> both byte streams are received in order with no loss.
